// File: rtl/serv_bus_arbiter.sv
// Two-master Wishbone arbiter: shares one slave port between the SERV
// instruction bus and data bus. Round-robin on contention, a mandatory
// idle turnaround cycle between grants, and an optional per-transaction
// timeout that terminates a hung access with all-ones read data.
module serv_bus_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        i_rst_n,
    // instruction fetch master
    input  logic [31:0] i_ibus_adr,
    input  logic        i_ibus_cyc,
    output logic [31:0] o_ibus_rdt,
    output logic        o_ibus_ack,
    // data master
    input  logic [31:0] i_dbus_adr,
    input  logic [31:0] i_dbus_dat,
    input  logic [3:0]  i_dbus_sel,
    input  logic        i_dbus_we,
    input  logic        i_dbus_cyc,
    output logic [31:0] o_dbus_rdt,
    output logic        o_dbus_ack,
    // shared slave port
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack,
    output logic        o_timeout
);

    // A zero TIMEOUT still needs a 1-bit counter so the declarations stay legal.
    localparam int unsigned   CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        GNT_I,
        GNT_D
    } state_e;

    typedef enum logic {
        LAST_I,
        LAST_D
    } side_e;

    state_e        state_q, state_d;
    side_e         last_gnt_q, last_gnt_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          gnt_cyc;
    logic          wait_expired;
    logic          ack_hit;
    logic          to_hit;
    logic          done;
    logic [31:0]   done_rdt;

    // Request line of whichever master currently owns the slave port.
    always_comb begin
        gnt_cyc = 1'b0;
        case (state_q)
            GNT_I:   gnt_cyc = i_ibus_cyc;
            GNT_D:   gnt_cyc = i_dbus_cyc;
            default: gnt_cyc = 1'b0;
        endcase
    end

    // An abort (owner drops cyc) suppresses both the ack and the timeout.
    assign wait_expired = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
    assign ack_hit      = gnt_cyc & i_wb_ack;
    assign to_hit       = gnt_cyc & ~i_wb_ack & wait_expired;
    assign done         = ack_hit | to_hit;
    assign done_rdt     = ack_hit ? i_wb_rdt : (to_hit ? '1 : '0);
    assign o_timeout    = to_hit;

    // Grant selection, turnaround and wait counting.
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (i_ibus_cyc && i_dbus_cyc) begin
                    if (last_gnt_q == LAST_D) begin
                        state_d    = GNT_I;
                        last_gnt_d = LAST_I;
                    end else begin
                        state_d    = GNT_D;
                        last_gnt_d = LAST_D;
                    end
                end else if (i_ibus_cyc) begin
                    state_d    = GNT_I;
                    last_gnt_d = LAST_I;
                end else if (i_dbus_cyc) begin
                    state_d    = GNT_D;
                    last_gnt_d = LAST_D;
                end
            end
            GNT_I, GNT_D: begin
                if (!gnt_cyc || done) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            last_gnt_q <= LAST_I;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            cnt_q      <= cnt_d;
        end
    end

    // Slave-port mux and completion routing, decoded from the registered state.
    always_comb begin
        o_wb_cyc   = 1'b0;
        o_wb_adr   = '0;
        o_wb_dat   = '0;
        o_wb_sel   = '0;
        o_wb_we    = 1'b0;
        o_ibus_ack = 1'b0;
        o_ibus_rdt = '0;
        o_dbus_ack = 1'b0;
        o_dbus_rdt = '0;
        case (state_q)
            GNT_I: begin
                o_wb_cyc   = 1'b1;
                o_wb_adr   = i_ibus_adr;
                o_wb_sel   = '1;
                o_ibus_ack = done;
                o_ibus_rdt = done_rdt;
            end
            GNT_D: begin
                o_wb_cyc   = 1'b1;
                o_wb_adr   = i_dbus_adr;
                o_wb_dat   = i_dbus_dat;
                o_wb_sel   = i_dbus_sel;
                o_wb_we    = i_dbus_we;
                o_dbus_ack = done;
                o_dbus_rdt = done_rdt;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_serv_bus_arbiter.sv
// Bench for serv_bus_arbiter (TIMEOUT = 4): directed vector table, hand
// sequences for timeout/abort/reset/round-robin, then random traffic
// against a cycle-level reference model of the arbitration rules.
module tb_serv_bus_arbiter;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic [31:0] i_ibus_adr;
    logic        i_ibus_cyc;
    logic [31:0] o_ibus_rdt;
    logic        o_ibus_ack;
    logic [31:0] i_dbus_adr;
    logic [31:0] i_dbus_dat;
    logic [3:0]  i_dbus_sel;
    logic        i_dbus_we;
    logic        i_dbus_cyc;
    logic [31:0] o_dbus_rdt;
    logic        o_dbus_ack;
    logic [31:0] o_wb_adr;
    logic [31:0] o_wb_dat;
    logic [3:0]  o_wb_sel;
    logic        o_wb_we;
    logic        o_wb_cyc;
    logic [31:0] i_wb_rdt;
    logic        i_wb_ack;
    logic        o_timeout;

    always #5 clk = ~clk;

    serv_bus_arbiter #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .i_rst_n    (i_rst_n),
        .i_ibus_adr (i_ibus_adr),
        .i_ibus_cyc (i_ibus_cyc),
        .o_ibus_rdt (o_ibus_rdt),
        .o_ibus_ack (o_ibus_ack),
        .i_dbus_adr (i_dbus_adr),
        .i_dbus_dat (i_dbus_dat),
        .i_dbus_sel (i_dbus_sel),
        .i_dbus_we  (i_dbus_we),
        .i_dbus_cyc (i_dbus_cyc),
        .o_dbus_rdt (o_dbus_rdt),
        .o_dbus_ack (o_dbus_ack),
        .o_wb_adr   (o_wb_adr),
        .o_wb_dat   (o_wb_dat),
        .o_wb_sel   (o_wb_sel),
        .o_wb_we    (o_wb_we),
        .o_wb_cyc   (o_wb_cyc),
        .i_wb_rdt   (i_wb_rdt),
        .i_wb_ack   (i_wb_ack),
        .o_timeout  (o_timeout)
    );

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // owner: 0 = nobody, 1 = ibus, 2 = dbus; waited = grant cycles already spent
    int unsigned m_owner, m_waited, m_last;
    logic        e_cyc, e_we, e_iack, e_dack, e_to, e_end;
    logic [31:0] e_adr, e_dat, e_irdt, e_drdt;
    logic [3:0]  e_sel;

    task automatic model_reset();
        m_owner  = 0;
        m_waited = 0;
        m_last   = 1;
    endtask

    task automatic model_expect();
        logic        req, fin;
        logic [31:0] rdt;
        e_cyc = 1'b0; e_we = 1'b0; e_adr = '0; e_dat = '0; e_sel = '0;
        e_iack = 1'b0; e_dack = 1'b0; e_irdt = '0; e_drdt = '0; e_to = 1'b0;
        req = 1'b0; fin = 1'b0; rdt = '0;
        if (m_owner == 1) begin
            e_cyc = 1'b1; e_adr = i_ibus_adr; e_sel = 4'hF; req = i_ibus_cyc;
        end else if (m_owner == 2) begin
            e_cyc = 1'b1; e_adr = i_dbus_adr; e_dat = i_dbus_dat;
            e_sel = i_dbus_sel; e_we = i_dbus_we; req = i_dbus_cyc;
        end
        if (m_owner != 0 && req) begin
            if (i_wb_ack) begin
                fin = 1'b1; rdt = i_wb_rdt;
            end else if (TO != 0 && m_waited + 1 == TO) begin
                fin = 1'b1; rdt = 32'hFFFFFFFF; e_to = 1'b1;
            end
        end
        if (m_owner == 1) begin e_iack = fin; e_irdt = rdt; end
        if (m_owner == 2) begin e_dack = fin; e_drdt = rdt; end
        e_end = (m_owner != 0) && (!req || fin);
    endtask

    task automatic model_step();
        model_expect();
        if (m_owner == 0) begin
            if (i_ibus_cyc && i_dbus_cyc) m_owner = (m_last == 2) ? 1 : 2;
            else if (i_ibus_cyc)          m_owner = 1;
            else if (i_dbus_cyc)          m_owner = 2;
            if (m_owner != 0) m_last = m_owner;
            m_waited = 0;
        end else if (e_end) begin
            m_owner  = 0;
            m_waited = 0;
        end else begin
            m_waited++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (!i_rst_n) model_reset();
        else model_step();
        #1;
    endtask

    task automatic check_all();
        model_expect();
        chk1("rnd_wb_cyc", o_wb_cyc, e_cyc);
        chk ("rnd_wb_adr", o_wb_adr, e_adr);
        chk ("rnd_wb_dat", o_wb_dat, e_dat);
        chk ("rnd_wb_sel", 32'(o_wb_sel), 32'(e_sel));
        chk1("rnd_wb_we", o_wb_we, e_we);
        chk1("rnd_ibus_ack", o_ibus_ack, e_iack);
        chk1("rnd_dbus_ack", o_dbus_ack, e_dack);
        chk1("rnd_timeout", o_timeout, e_to);
        if (e_iack || m_owner != 1) chk("rnd_ibus_rdt", o_ibus_rdt, e_irdt);
        if (e_dack || m_owner != 2) chk("rnd_dbus_rdt", o_dbus_rdt, e_drdt);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        ic, dc, ack;
        logic [31:0] rdt;
        logic        e_cyc, e_we;
        logic [31:0] e_adr, e_dat;
        logic [3:0]  e_sel;
        logic        e_iack, e_dack, e_to;
        logic [31:0] e_irdt, e_drdt;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // both contend after reset: dbus first, idle turnaround, then ibus;
        // ibus ack lands 3 cycles after its first o_wb_cyc (the timeout cycle)
        vecs[0] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h2000, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 32'h11111111, 1'b1, 1'b1, 32'h2000, 32'hDEADBEEF, 4'hF, 1'b0, 1'b1, 1'b0, 32'h0,  32'h11111111};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h100,  32'h0,        4'hF, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h100,  32'h0,        4'hF, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h100,  32'h0,        4'hF, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 32'h13,       1'b1, 1'b0, 32'h100,  32'h0,        4'hF, 1'b1, 1'b0, 1'b0, 32'h13, 32'h0};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0};

        // reset with every request and the slave ack active: outputs must stay quiet
        i_rst_n    = 1'b0;
        i_ibus_adr = 32'h100;
        i_ibus_cyc = 1'b1;
        i_dbus_adr = 32'h2000;
        i_dbus_dat = 32'hDEADBEEF;
        i_dbus_sel = 4'hF;
        i_dbus_we  = 1'b1;
        i_dbus_cyc = 1'b1;
        i_wb_rdt   = 32'hCAFEF00D;
        i_wb_ack   = 1'b1;
        model_reset();
        step();
        step();
        @(negedge clk);
        chk1("rst_wb_cyc", o_wb_cyc, 1'b0);
        chk1("rst_ibus_ack", o_ibus_ack, 1'b0);
        chk1("rst_dbus_ack", o_dbus_ack, 1'b0);
        chk1("rst_timeout", o_timeout, 1'b0);
        chk ("rst_wb_adr", o_wb_adr, 32'h0);
        chk ("rst_ibus_rdt", o_ibus_rdt, 32'h0);
        chk ("rst_dbus_rdt", o_dbus_rdt, 32'h0);
        i_rst_n    = 1'b1;
        i_ibus_cyc = 1'b0;
        i_dbus_cyc = 1'b0;
        i_wb_ack   = 1'b0;
        i_wb_rdt   = 32'h0;
        step();

        // table phase
        for (int unsigned v = 0; v < 9; v++) begin
            i_ibus_cyc = vecs[v].ic;
            i_dbus_cyc = vecs[v].dc;
            i_wb_ack   = vecs[v].ack;
            i_wb_rdt   = vecs[v].rdt;
            @(negedge clk);
            chk1("vec_wb_cyc", o_wb_cyc, vecs[v].e_cyc);
            chk1("vec_wb_we", o_wb_we, vecs[v].e_we);
            chk ("vec_wb_adr", o_wb_adr, vecs[v].e_adr);
            chk ("vec_wb_dat", o_wb_dat, vecs[v].e_dat);
            chk ("vec_wb_sel", 32'(o_wb_sel), 32'(vecs[v].e_sel));
            chk1("vec_ibus_ack", o_ibus_ack, vecs[v].e_iack);
            chk1("vec_dbus_ack", o_dbus_ack, vecs[v].e_dack);
            chk1("vec_timeout", o_timeout, vecs[v].e_to);
            chk ("vec_ibus_rdt", o_ibus_rdt, vecs[v].e_irdt);
            chk ("vec_dbus_rdt", o_dbus_rdt, vecs[v].e_drdt);
            step();
        end

        // dbus read that the slave never acks: forced completion on 4th grant cycle
        i_dbus_we  = 1'b0;
        i_dbus_adr = 32'h3000;
        i_dbus_cyc = 1'b1;
        i_wb_ack   = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k == 5) i_dbus_cyc = 1'b0;
            @(negedge clk);
            chk1("to_wb_cyc", o_wb_cyc, (k >= 1 && k <= 4));
            chk1("to_dbus_ack", o_dbus_ack, (k == 4));
            chk1("to_flag", o_timeout, (k == 4));
            if (k == 4) chk("to_dbus_rdt", o_dbus_rdt, 32'hFFFFFFFF);
            step();
        end

        // ibus aborts after one grant cycle: no ack, no timeout, port released
        i_ibus_cyc = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k == 2) i_ibus_cyc = 1'b0;
            @(negedge clk);
            chk1("abort_wb_cyc", o_wb_cyc, (k == 1 || k == 2));
            chk1("abort_ibus_ack", o_ibus_ack, 1'b0);
            chk1("abort_timeout", o_timeout, 1'b0);
            step();
        end

        // reset pulse while ibus owns the port, then a stray slave ack
        begin
            bit seen = 1'b0;
            i_ibus_cyc = 1'b1;
            for (int k = 0; k < 6 && !seen; k++) begin
                @(negedge clk);
                if (o_wb_cyc) seen = 1'b1;
                else step();
            end
            chk1("rstmid_grant_seen", seen, 1'b1);
            i_rst_n = 1'b0;
            model_reset();
            #1;
            chk1("rstmid_wb_cyc", o_wb_cyc, 1'b0);
            chk1("rstmid_ibus_ack", o_ibus_ack, 1'b0);
            #1;
            i_ibus_cyc = 1'b0;
            i_wb_ack   = 1'b1;
            i_wb_rdt   = 32'h12345678;
            i_rst_n    = 1'b1;
            step();
            for (int k = 0; k < 2; k++) begin
                @(negedge clk);
                chk1("rstmid_stray_ack", o_ibus_ack, 1'b0);
                chk1("rstmid_stray_cyc", o_wb_cyc, 1'b0);
                chk1("rstmid_stray_to", o_timeout, 1'b0);
                step();
            end
            i_wb_ack = 1'b0;
        end

        // both masters re-request continuously: D,I,D,I,... from reset
        begin
            int unsigned got  = 0;
            int unsigned side;
            @(negedge clk);
            i_rst_n = 1'b0;
            model_reset();
            i_ibus_adr = 32'h100;
            i_dbus_adr = 32'h2000;
            i_ibus_cyc = 1'b1;
            i_dbus_cyc = 1'b1;
            i_wb_ack   = 1'b0;
            #1;
            i_rst_n = 1'b1;
            step();
            for (int k = 0; k < 100 && got < 8; k++) begin
                @(negedge clk);
                if (o_wb_cyc) begin
                    side = (o_wb_adr == 32'h2000) ? 2 : 1;
                    chk("alt_side", 32'(side), ((got % 2) == 0) ? 32'd2 : 32'd1);
                    got++;
                    i_wb_ack = 1'b1;
                end
                step();
                i_wb_ack = 1'b0;
            end
            chk("alt_grant_count", 32'(got), 32'd8);
            i_ibus_cyc = 1'b0;
            i_dbus_cyc = 1'b0;
            step();
        end

        // random traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            if (i_ibus_cyc) i_ibus_cyc = ($urandom_range(0, 9) != 0);
            else            i_ibus_cyc = ($urandom_range(0, 1) == 1);
            if (i_dbus_cyc) i_dbus_cyc = ($urandom_range(0, 9) != 0);
            else            i_dbus_cyc = ($urandom_range(0, 1) == 1);
            i_ibus_adr = $urandom;
            i_dbus_adr = $urandom;
            i_dbus_dat = $urandom;
            i_dbus_sel = 4'($urandom);
            i_dbus_we  = 1'($urandom);
            i_wb_rdt   = $urandom;
            i_wb_ack   = ($urandom_range(0, 4) == 0);
            @(negedge clk);
            check_all();
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
